// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the write-back requester handshakes, register-file write port,
// issue port and decode-stage stall signals around rf_wb_arbiter.
interface rf_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_data;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_data;

  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;

  logic                  issue_valid;
  logic [ADDR_WIDTH-1:0] issue_addr;

  logic [ADDR_WIDTH-1:0] raddr_1;
  logic [ADDR_WIDTH-1:0] raddr_2;
  logic                  stall_1;
  logic                  stall_2;
  logic [NUM_REGS-1:0]   busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  issue_valid, issue_addr, raddr_1, raddr_2,
    output req0_ready, req1_ready,
    output rf_wen, rf_waddr, rf_wdata,
    output stall_1, stall_2, busy
  );

  // Requester / pipeline side
  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output issue_valid, issue_addr, raddr_1, raddr_2,
    input  req0_ready, req1_ready,
    input  rf_wen, rf_waddr, rf_wdata,
    input  stall_1, stall_2, busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter feeding a registered register-file write port,
// plus a per-register busy scoreboard that drives decode RAW stalls.
module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  rf_wb_arbiter_if.slave   bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic                  prio_reg;
  logic                  prio_next;
  logic                  grant0;
  logic                  grant1;
  logic                  accept;

  logic                  rf_wen_reg;
  logic                  rf_wen_next;
  logic [ADDR_WIDTH-1:0] rf_waddr_reg;
  logic [ADDR_WIDTH-1:0] rf_waddr_next;
  logic [DATA_WIDTH-1:0] rf_wdata_reg;
  logic [DATA_WIDTH-1:0] rf_wdata_next;

  logic [NUM_REGS-1:0]   busy_reg;
  logic [NUM_REGS-1:0]   busy_next;

  // A lone requester always wins; prio only breaks ties.
  assign grant0 = bus.req0_valid && (!bus.req1_valid || !prio_reg);
  assign grant1 = bus.req1_valid && (!bus.req0_valid ||  prio_reg);
  assign accept = grant0 || grant1;

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_comb begin
    prio_next     = prio_reg;
    rf_wen_next   = 1'b0;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    if (grant0) begin
      prio_next     = 1'b1;
      rf_waddr_next = bus.req0_addr;
      rf_wdata_next = bus.req0_data;
      rf_wen_next   = (bus.req0_addr != '0);
    end else if (grant1) begin
      prio_next     = 1'b0;
      rf_waddr_next = bus.req1_addr;
      rf_wdata_next = bus.req1_data;
      rf_wen_next   = (bus.req1_addr != '0);
    end
  end

  // Set beats clear so a re-issue racing the old write-back stays busy.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit = bus.issue_valid && (bus.issue_addr == ADDR_WIDTH'(gi));
        assign clr_hit = rf_wen_reg && (rf_waddr_reg == ADDR_WIDTH'(gi));
        assign busy_next[gi] = set_hit || (busy_reg[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_reg     <= 1'b0;
      rf_wen_reg   <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      busy_reg     <= '0;
    end else begin
      prio_reg     <= accept ? prio_next : prio_reg;
      rf_wen_reg   <= rf_wen_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
      busy_reg     <= busy_next;
    end
  end

  assign bus.rf_wen   = rf_wen_reg;
  assign bus.rf_waddr = rf_waddr_reg;
  assign bus.rf_wdata = rf_wdata_reg;
  assign bus.busy     = busy_reg;
  assign bus.stall_1  = busy_reg[bus.raddr_1];
  assign bus.stall_2  = busy_reg[bus.raddr_2];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: arbitration vector table plus
// hand-written scoreboard, same-cycle set/clear and async-reset sequences.
module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rf_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          r0;
    logic          r1;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } vec_t;

  typedef struct {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
  } wr_t;

  vec_t vecs[11];
  wr_t  exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic v0, int a0, logic [DW-1:0] d0,
                              logic v1, int a1, logic [DW-1:0] d1,
                              logic r0, logic r1,
                              logic wen, int waddr, logic [DW-1:0] wdata);
    vec_t v;
    v.v0 = v0; v.a0 = AW'(a0); v.d0 = d0;
    v.v1 = v1; v.a1 = AW'(a1); v.d1 = d1;
    v.r0 = r0; v.r1 = r1;
    v.wen = wen; v.waddr = AW'(waddr); v.wdata = wdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input int a0, input logic [DW-1:0] d0,
                       input logic v1, input int a1, input logic [DW-1:0] d1);
    bus.req0_valid = v0; bus.req0_addr = AW'(a0); bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = AW'(a1); bus.req1_data = d1;
  endtask

  task automatic push_exp(input logic wen, input int waddr, input logic [DW-1:0] wdata);
    wr_t w;
    w.wen = wen; w.waddr = AW'(waddr); w.wdata = wdata;
    exp_q.push_back(w);
  endtask

  // Called one edge after the push: the registered write port must match.
  task automatic pop_check(input string tag);
    wr_t w;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    w = exp_q.pop_front();
    chk({tag, ".rf_wen"},   64'(bus.rf_wen),   64'(w.wen));
    chk({tag, ".rf_waddr"}, 64'(bus.rf_waddr), 64'(w.waddr));
    chk({tag, ".rf_wdata"}, 64'(bus.rf_wdata), 64'(w.wdata));
    $display("txn %s: wen=%0b waddr=%0d wdata=%08h busy=%08h",
             tag, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.busy);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 32'h0,  1, 0, 1, 3, 32'hDEADBEEF);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 3, 32'hDEADBEEF);
    vecs[2]  = mk(0, 0, 32'h0,        1, 4, 32'h44, 0, 1, 1, 4, 32'h44);
    vecs[3]  = mk(1, 1, 32'h11,       1, 2, 32'h22, 1, 0, 1, 1, 32'h11);
    vecs[4]  = mk(1, 1, 32'h11,       1, 2, 32'h22, 0, 1, 1, 2, 32'h22);
    vecs[5]  = mk(1, 1, 32'h11,       1, 2, 32'h22, 1, 0, 1, 1, 32'h11);
    vecs[6]  = mk(1, 1, 32'h11,       1, 2, 32'h22, 0, 1, 1, 2, 32'h22);
    vecs[7]  = mk(0, 0, 32'h0,        1, 0, 32'h55, 0, 1, 0, 0, 32'h55);
    vecs[8]  = mk(1, 6, 32'h66,       1, 9, 32'h99, 1, 0, 1, 6, 32'h66);
    vecs[9]  = mk(1, 6, 32'h67,       1, 9, 32'h99, 0, 1, 1, 9, 32'h99);
    vecs[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,  0, 0, 0, 9, 32'h99);

    drive(0, 0, 0, 0, 0, 0);
    bus.issue_valid = 1'b0; bus.issue_addr = '0;
    bus.raddr_1 = '0; bus.raddr_2 = '0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("reset.rf_wen",   64'(bus.rf_wen),   64'd0);
    chk("reset.rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("reset.rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("reset.busy",     64'(bus.busy),     64'd0);
    step();
    step();
    rst = 1'b0;

    // Arbitration table
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v0, int'(vecs[i].a0), vecs[i].d0, vecs[i].v1, int'(vecs[i].a1), vecs[i].d1);
      #1;
      chk($sformatf("vec%0d.req0_ready", i), 64'(bus.req0_ready), 64'(vecs[i].r0));
      chk($sformatf("vec%0d.req1_ready", i), 64'(bus.req1_ready), 64'(vecs[i].r1));
      push_exp(vecs[i].wen, int'(vecs[i].waddr), vecs[i].wdata);
      step();
      pop_check($sformatf("vec%0d", i));
    end

    // Scoreboard: issue 7, stall until its write-back edge has passed
    drive(0, 0, 0, 0, 0, 0);
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd7;
    bus.raddr_1 = 5'd7; bus.raddr_2 = 5'd3;
    #1 chk("sbA.stall_before_issue", 64'(bus.stall_1), 64'd0);
    step();
    bus.issue_valid = 1'b0;
    chk("sbA.stall_1_after_issue", 64'(bus.stall_1), 64'd1);
    chk("sbA.stall_2_other",       64'(bus.stall_2), 64'd0);
    chk("sbA.busy_vec",            64'(bus.busy),    64'h80);
    step();
    chk("sbA.stall_1_held", 64'(bus.stall_1), 64'd1);
    drive(1, 7, 32'hA5A5_0007, 0, 0, 0);
    #1 chk("sbA.req0_ready", 64'(bus.req0_ready), 64'd1);
    push_exp(1, 7, 32'hA5A5_0007);
    step();
    drive(0, 0, 0, 0, 0, 0);
    pop_check("sbA.wb7");
    chk("sbA.stall_during_wb", 64'(bus.stall_1), 64'd1);
    step();
    chk("sbA.stall_after_wb", 64'(bus.stall_1), 64'd0);
    chk("sbA.busy_cleared",   64'(bus.busy),    64'd0);

    // Re-issue of 7 on the same edge as its write-back keeps it busy
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd7;
    step();
    bus.issue_valid = 1'b0;
    drive(1, 7, 32'h0000_0B07, 0, 0, 0);
    push_exp(1, 7, 32'h0000_0B07);
    step();
    drive(0, 0, 0, 0, 0, 0);
    pop_check("sbB.wb7");
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd7;
    step();
    bus.issue_valid = 1'b0;
    chk("sbB.busy7_kept", 64'(bus.busy), 64'h80);
    chk("sbB.stall_1",    64'(bus.stall_1), 64'd1);
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd0;
    bus.raddr_2 = 5'd0;
    step();
    bus.issue_valid = 1'b0;
    chk("sbB.busy0_never", 64'(bus.busy), 64'h80);
    chk("sbB.stall_2_r0",  64'(bus.stall_2), 64'd0);
    drive(1, 7, 32'h0000_0C07, 0, 0, 0);
    push_exp(1, 7, 32'h0000_0C07);
    step();
    drive(0, 0, 0, 0, 0, 0);
    pop_check("sbB.wb7b");
    step();
    chk("sbB.busy_cleared", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-cycle with a write in flight
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd5;
    bus.raddr_1 = 5'd5;
    step();
    bus.issue_valid = 1'b0;
    drive(1, 5, 32'h0000_00C3, 0, 0, 0);
    push_exp(1, 5, 32'h0000_00C3);
    step();
    drive(0, 0, 0, 0, 0, 0);
    pop_check("rst.wb5");
    chk("rst.busy5_before", 64'(bus.busy[5]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst.rf_wen",   64'(bus.rf_wen),   64'd0);
    chk("rst.rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst.rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("rst.busy",     64'(bus.busy),     64'd0);
    chk("rst.stall_1",  64'(bus.stall_1),  64'd0);
    drive(1, 1, 32'h1, 1, 2, 32'h2);
    #1;
    chk("rst.prio_req0_ready", 64'(bus.req0_ready), 64'd1);
    chk("rst.prio_req1_ready", 64'(bus.req1_ready), 64'd0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard in front of the register file's single write port. Two write-back requesters (req0: ALU/CSR path, req1: load path) compete through valid/ready handshakes. A round-robin grant moves one write per cycle into a registered stage that drives the register file's write port. A per-register busy scoreboard, set at issue and cleared at write-back, gives the decode stage read-after-write stall signals for its two read addresses.

## Interface
- ADDR_WIDTH, default 5, register address width; register count is 2**ADDR_WIDTH
- DATA_WIDTH, default 32, register data width
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has a write pending
- req0_ready  output  1  requester 0 granted this cycle
- req0_addr  input  ADDR_WIDTH  requester 0 destination register
- req0_data  input  DATA_WIDTH  requester 0 write data
- req1_valid, req1_ready, req1_addr, req1_data: same as req0, for requester 1
- rf_wen  output  1  register-file write enable
- rf_waddr  output  ADDR_WIDTH  register-file write address
- rf_wdata  output  DATA_WIDTH  register-file write data
- issue_valid  input  1  an instruction with a destination register is issued
- issue_addr  input  ADDR_WIDTH  destination register of the issued instruction
- raddr_1, raddr_2  input  ADDR_WIDTH  decode-stage read addresses
- stall_1, stall_2  output  1  the matching read address is busy
- busy  output  2**ADDR_WIDTH  scoreboard vector, bit i set means register i has a write outstanding

## Operation
- Priority register prio, 1 bit: 0 means req0 is preferred, 1 means req1 is preferred. Reset value is 0.
- Grant logic is combinational:
  - Only req0_valid set: grant req0.
  - Only req1_valid set: grant req1.
  - Both set: grant the requester named by prio.
  - Neither set: no grant.
- reqN_ready is 1 only when requester N is granted, so ready depends on valid.
- A write is accepted when valid and ready are both 1. At most one write is accepted per cycle.
- On an accepted write, prio is set to point at the non-granted requester. prio does not change in a cycle with no grant.
- A requester must hold valid, addr and data stable until it is accepted.
- Output stage: on acceptance, the granted addr and data are registered into rf_waddr and rf_wdata.
  - rf_wen is registered as 1 if the accepted address is non-zero, else 0. Writes to register 0 are accepted and then discarded.
  - With no acceptance, rf_wen is registered as 0. rf_waddr and rf_wdata hold their previous values.
- Scoreboard, busy[i] at each posedge:
  - Cleared when rf_wen is 1 and rf_waddr == i (the write happening this edge).
  - Set when issue_valid is 1, issue_addr == i and i != 0.
  - If set and clear hit the same index in the same cycle, set wins, because a newer producer is outstanding.
  - busy[0] is constant 0.
- Stall outputs are combinational: stall_1 = busy[raddr_1], stall_2 = busy[raddr_2].
- No bypass: a register is still busy during the cycle its write is on rf_wen, and frees after that edge.

## Timing
- Reset values, forced immediately on rst assertion and independent of clk:
  - rf_wen = 0, rf_waddr = 0, rf_wdata = 0
  - prio = 0
  - busy = all zeros, so stall_1 = stall_2 = 0
- reqN_ready has no defined reset value: it follows the valid inputs combinationally, with prio = 0.
- A write in the output stage when rst asserts is lost. A requester waiting on ready at reset must re-present its write after reset.
- Cycle timing for a write accepted at edge E:
  - rf_wen, rf_waddr and rf_wdata are valid from E until E+1.
  - The register file stores the data at edge E+1.
  - busy clears at edge E+1.
- Accept latency to register-file update is one cycle. Throughput is one write per cycle.
- Issue at edge E: busy is set from E, so stall is visible to decode in the cycle after issue.
- Starvation bound: with both requesters valid continuously, grants strictly alternate, so each requester waits at most one cycle.

## Test plan
- Reset, then req0 writes addr 3, data 0xDEADBEEF: req0_ready = 1 in the same cycle; next cycle rf_wen = 1, rf_waddr = 3, rf_wdata = 0xDEADBEEF; following cycle rf_wen = 0.
- Both requesters valid continuously for 4 cycles (req0 addr 1, req1 addr 2): grants are req0, req1, req0, req1; rf_waddr sequence is 1, 2, 1, 2.
- req1 writes addr 0, data 0x55: req1_ready = 1, rf_wen stays 0 the next cycle, prio flips to 0.
- Issue addr 7, then raddr_1 = 7: stall_1 = 1 until the req0 write to 7 has rf_wen high for one cycle; stall_1 = 0 on the following cycle.
- Issue addr 7 in the same cycle that rf_wen writes addr 7 (already busy): busy[7] stays 1 afterwards.
- rst asserted mid-cycle while rf_wen = 1 and busy[5] = 1: rf_wen, busy and prio go to 0 immediately, without a clock edge.
